// File: rtl/ram_latency_model.sv
// Word-addressed single-port backing memory with a fixed access latency and a busy/done handshake.
// Define RAM_INIT_PATTERN_EN to make every word start out holding its own index.
module ram_latency_model #(
    parameter int SIZE       = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mode,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic [31:0] out,
    output logic        response
);

    typedef enum logic {IDLE, BUSY} state_t;

`ifdef RAM_INIT_PATTERN_EN
    localparam bit PATTERN_EN = 1'b1;
`else
    localparam bit PATTERN_EN = 1'b0;
`endif

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                  state;
    state_t                  next_state;
    logic [7:0]              cnt;
    logic [7:0]              cnt_next;
    logic                    accept;
    logic                    complete;
    logic [ADDR_WIDTH-1:0]   a_q;
    logic                    mode_q;
    logic [31:0]             data_q;
    logic [31:0]             pattern_word;
    logic [31:0]             read_word;
    logic                    do_write;
    logic                    unused_addr_hi;

    // Words are stored XOR'd with their power-up image, so an all-zero array
    // represents either the blank or the index-pattern memory without any reload logic.
    logic [31:0] mem [0:SIZE-1] = '{default: '0};

    assign unused_addr_hi = ^address[31:ADDR_WIDTH];
    assign pattern_word   = PATTERN_EN ? 32'(a_q) : 32'h0;
    assign read_word      = mem[a_q] ^ pattern_word;
    assign do_write       = complete && mode_q && !reset;
    assign response       = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture and result register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= 32'h0;
        end else begin
            if (accept) begin
                a_q    <= address[ADDR_WIDTH-1:0];
                mode_q <= mode;
                data_q <= data;
            end
            if (complete) begin
                out <= mode_q ? data_q : read_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[a_q] <= data_q ^ pattern_word;
        end
    end

endmodule

// File: tb/tb_ram_latency_model.sv
// Scoreboard bench for ram_latency_model: stimulus pushes expected results, a negedge monitor checks them.
module tb_ram_latency_model;

    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        mode;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] out;
    logic        response;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expq[$];
    logic        prev_resp = 1'b0;

    ram_latency_model #(
        .SIZE(4096),
        .ADDR_WIDTH(12),
        .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .mode(mode),
        .address(address),
        .data(data),
        .out(out),
        .response(response)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input logic [31:0] a);
`ifdef RAM_INIT_PATTERN_EN
        return {20'h0, a[11:0]};
`else
        return 32'h0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Every falling edge of response marks a finished (or aborted) access.
    always @(negedge clk) begin
        if (prev_resp && !response) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_completion", 32'h1, 32'h0);
            end else begin
                checkOutput("scoreboard_out", out, expq.pop_front());
            end
        end
        prev_resp = response;
    end

    task automatic applyStimulus(input logic m, input logic [31:0] addr, input logic [31:0] d,
                                 input logic [31:0] exp_out);
        int busy;
        @(negedge clk);
        req = 1'b1; mode = m; address = addr; data = d;
        expq.push_back(exp_out);
        @(negedge clk);
        req = 1'b0;
        busy = 0;
        while (response && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 32'(busy), 32'(LATENCY));
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; mode = 1'b0; address = 32'h0; data = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_response", 32'(response), 32'h0);
        checkOutput("reset_out", out, 32'h0);

        applyStimulus(1'b0, 32'h5, 32'h0, initWord(32'h5));

        applyStimulus(1'b1, 32'h010, 32'hDEADBEEF, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h010, 32'h0, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        checkOutput("out_hold", out, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h1010, 32'h000000A5, 32'h000000A5);
        applyStimulus(1'b0, 32'h010, 32'h0, 32'h000000A5);

        // Read 0x010 at edge k, stray write requests at k+2 and at the completion edge k+4.
        @(negedge clk);
        req = 1'b1; mode = 1'b0; address = 32'h010;
        expq.push_back(32'h000000A5);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; mode = 1'b1; address = 32'h020; data = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checkOutput("busy_ignores_req", 32'(response), 32'h1);
        req = 1'b1; mode = 1'b1; address = 32'h020; data = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        checkOutput("done_at_k4", 32'(response), 32'h0);
        @(negedge clk);
        checkOutput("completion_req_dropped", 32'(response), 32'h0);
        applyStimulus(1'b0, 32'h020, 32'h0, initWord(32'h020));

        // Write to 0x030 aborted by reset at edge k+2.
        @(negedge clk);
        req = 1'b1; mode = 1'b1; address = 32'h030; data = 32'h12345678;
        expq.push_back(32'h0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_response", 32'(response), 32'h0);
        checkOutput("abort_out", out, 32'h0);
        applyStimulus(1'b0, 32'h030, 32'h0, initWord(32'h030));

        // Reset and request on the same edge: request is dropped.
        @(negedge clk);
        reset = 1'b1; req = 1'b1; mode = 1'b0; address = 32'h5;
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        checkOutput("reset_beats_req", 32'(response), 32'h0);
        @(negedge clk);
        checkOutput("reset_beats_req_later", 32'(response), 32'h0);

        applyStimulus(1'b0, 32'h123, 32'h0, initWord(32'h123));
        applyStimulus(1'b0, 32'h1123, 32'h0, initWord(32'h123));
        applyStimulus(1'b1, 32'hFFF, 32'h0F0F0F0F, 32'h0F0F0F0F);
        applyStimulus(1'b0, 32'h7FFF, 32'h0, 32'h0F0F0F0F);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
